mc_control_unit: RTL and testbench
==================================

Name: mc_control_unit

Overview:
- Multi-cycle control FSM that sits directly upstream of the 16x16-bit register file.
- Owns PC and IR, fetches 16-bit instructions and decodes them.
- Drives register-file read/write addresses and enables, ALU controls and the data-memory handshake.
- Consumes the ALU zero flag; the register file's read buses feed the ALU.

Parameters:
- PC_W, 16, program counter / instruction address width (word addressed)
- RESET_PC, 16'h0000, PC value loaded on reset

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  instruction fetch request, held high in FETCH until imem_valid
- imem_addr  out  PC_W  fetch address, equals pc
- imem_rdata  in  16  instruction word, sampled when imem_valid=1
- imem_valid  in  1  fetch data valid, any number of wait cycles allowed
- rf_ra  out  4  register file read address A
- rf_rb  out  4  register file read address B
- rf_rw  out  4  register file write address
- rf_rd_en  out  1  register file read enable (latches BusA/BusB on next clk edge)
- rf_wr_en  out  1  register file write enable, single-cycle pulse
- alu_op  out  2  00 AND, 01 ADD, 10 SUB
- alu_src_imm  out  1  ALU operand B = imm_ext when 1, else BusB
- imm_ext  out  16  sign-extended imm4 from IR[3:0]
- alu_zero  in  1  ALU result == 0, valid in EXEC
- wb_sel  out  1  write-back source: 0 ALU, 1 memory
- dmem_req  out  1  data memory request, held in MEM until dmem_ready
- dmem_we  out  1  1 = store, valid with dmem_req
- dmem_ready  in  1  data memory access complete
- pc  out  PC_W  current program counter
- illegal_op  out  1  one-cycle pulse in DECODE for reserved opcode
- halted  out  1  high while in HALT

Behaviour:
- Instruction format: op = IR[15:12], rd = IR[11:8], rs1 = IR[7:4], rs2/imm4 = IR[3:0].
- Opcodes:
  - 0 AND, 1 ADD, 2 SUB, 3 ADDI (rd = rs1 + sext(imm4))
  - 4 LW (rd = M[rs1 + sext(imm4)]), 5 SW (M[rs1 + sext(imm4)] = rd)
  - 6 BEQ (if rd == rs1 then pc += sext(imm4))
  - 7 JMP (pc = {pc[15:12], IR[11:0]})
  - 8-14 reserved, treated as NOP
  - 15 HALT
- Reset (async, rst_n=0):
  - state = FETCH, pc = RESET_PC, IR = 0.
  - All request/enable/pulse outputs 0: imem_req, rf_rd_en, rf_wr_en, dmem_req, dmem_we, illegal_op, halted.
  - alu_op = 00, alu_src_imm = 0, wb_sel = 0.
  - Reset mid-access abandons the access; no write pulse is issued.
- Outputs are Moore (decoded from state and IR), except imem_req/dmem_req, which drop in the cycle after valid/ready is seen.
- FETCH: imem_req = 1. When imem_valid = 1: IR <= imem_rdata, pc <= pc + 1 (wraps at 2^PC_W), go to DECODE.
- DECODE: rf_rd_en = 1.
  - rf_ra = rs1.
  - rf_rb = rs2 for R-type; rf_rb = rd for SW and BEQ.
  - Next state:
    - JMP: load pc, go to FETCH.
    - HALT: go to HALT.
    - Reserved opcode: pulse illegal_op, go to FETCH.
    - All others: go to EXEC.
- EXEC: alu_op and alu_src_imm are valid.
  - ADDI/LW/SW: ADD with imm.
  - BEQ: SUB with reg operand. If alu_zero = 1, pc <= pc + imm_ext, using the already-incremented pc; then go to FETCH.
  - R-type/ADDI: go to WB.
  - LW/SW: go to MEM.
- MEM: dmem_req = 1, dmem_we = (op == SW). Stay until dmem_ready.
  - LW: go to WB.
  - SW: go to FETCH.
- WB: rf_wr_en = 1 for exactly one cycle, rf_rw = rd, wb_sel = (op == LW). Then go to FETCH.
- HALT: halted = 1. Terminal until reset.
- Cycle counts with zero wait states:
  - R-type/ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ: 3
  - JMP: 2
  - Reserved: 2
- rf_rw = rd is held stable in all states, so an edge on rf_wr_en never writes a stale address.
- Writes to R0 are permitted; R0 is an ordinary register.

Decomposition:
- ctrl_pkg holds:
  - opcode constants OP_AND..OP_HALT
  - state encoding (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - ALU op constants
- One combinational sub-module, instr_decode, maps IR to: rf_ra/rb/rw, imm_ext, alu_op, alu_src_imm, wb_sel, is_mem, is_store, is_branch, is_jump, is_halt, is_illegal.
- mc_control_unit holds the FSM, PC and IR.

Test Plan:
- Reset to 0 mid-FETCH with imem_valid high -> pc = 0, state = FETCH, no rf_wr_en. After release, imem_addr = 0 and imem_req = 1 on the first cycle.
- ADD instr 16'h1312, imem_valid with 2 wait cycles -> DECODE has rf_ra = 1, rf_rb = 2. WB has rf_rw = 3 and a single-cycle rf_wr_en, wb_sel = 0. pc = 1. Total 6 cycles.
- LW 16'h452F with dmem_ready delayed 3 cycles -> EXEC: alu_op = ADD, alu_src_imm = 1, imm_ext = 16'hFFFF. dmem_req held 4 cycles with dmem_we = 0. WB: rf_rw = 5, wb_sel = 1.
- BEQ 16'h612E at pc = 10:
  - alu_zero = 1 -> next fetch address 9 (11 - 2).
  - alu_zero = 0 -> next fetch address 11; no rf_wr_en either way.
- JMP 16'h7ABC at pc = 16'h5000 -> next imem_addr = 16'h5ABC after 2 cycles.
- Opcode 16'h9000 -> illegal_op pulse 1 cycle, fetch continues at pc + 1. Then 16'hF000 -> halted = 1, imem_req stays 0 indefinitely.

Source files
------------

// File: rtl/mc_control_unit_pkg.sv
// Shared opcode, ALU-op and FSM-state definitions for the multi-cycle control unit.
// Also holds the decoded-instruction record passed from instr_decode to the FSM.
package ctrl_pkg;

    localparam logic [3:0] OP_AND  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_ADDI = 4'd3;
    localparam logic [3:0] OP_LW   = 4'd4;
    localparam logic [3:0] OP_SW   = 4'd5;
    localparam logic [3:0] OP_BEQ  = 4'd6;
    localparam logic [3:0] OP_JMP  = 4'd7;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [1:0] ALU_AND = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic [3:0]  rf_ra;
        logic [3:0]  rf_rb;
        logic [3:0]  rf_rw;
        logic [15:0] imm_ext;
        logic [1:0]  alu_op;
        logic        alu_src_imm;
        logic        wb_sel;
        logic        is_mem;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        is_halt;
        logic        is_illegal;
    } decode_t;

    // Opcodes 8..14 carry no function and execute as a NOP.
    function automatic logic op_is_reserved(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd14);
    endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Bus bundle between the control unit and its instruction memory, register file,
// ALU and data memory. The control unit is the master.
interface mc_control_unit_if #(
    parameter int PC_W = 16
);
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic [15:0]     imem_rdata;
    logic            imem_valid;

    logic [3:0]      rf_ra;
    logic [3:0]      rf_rb;
    logic [3:0]      rf_rw;
    logic            rf_rd_en;
    logic            rf_wr_en;

    logic [1:0]      alu_op;
    logic            alu_src_imm;
    logic [15:0]     imm_ext;
    logic            alu_zero;
    logic            wb_sel;

    logic            dmem_req;
    logic            dmem_we;
    logic            dmem_ready;

    modport master (
        output imem_req, imem_addr,
        input  imem_rdata, imem_valid,
        output rf_ra, rf_rb, rf_rw, rf_rd_en, rf_wr_en,
        output alu_op, alu_src_imm, imm_ext, wb_sel,
        input  alu_zero,
        output dmem_req, dmem_we,
        input  dmem_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_rdata, imem_valid,
        input  rf_ra, rf_rb, rf_rw, rf_rd_en, rf_wr_en,
        input  alu_op, alu_src_imm, imm_ext, wb_sel,
        output alu_zero,
        input  dmem_req, dmem_we,
        output dmem_ready
    );

endinterface

// File: rtl/mc_control_unit_instr_decode.sv
// Purely combinational instruction decoder: IR fields to register addresses,
// immediate, ALU controls and instruction-class flags.
module instr_decode
    import ctrl_pkg::*;
(
    input  logic [15:0] i_ir,
    output decode_t     o_dec
);

    logic [3:0] w_op;
    logic [3:0] w_rd;
    logic [3:0] w_rs1;
    logic [3:0] w_rs2;

    assign w_op  = i_ir[15:12];
    assign w_rd  = i_ir[11:8];
    assign w_rs1 = i_ir[7:4];
    assign w_rs2 = i_ir[3:0];

    always_comb begin
        o_dec             = '0;
        o_dec.rf_ra       = w_rs1;
        o_dec.rf_rb       = w_rs2;
        o_dec.rf_rw       = w_rd;
        o_dec.imm_ext     = {{12{i_ir[3]}}, i_ir[3:0]};
        o_dec.alu_op      = ALU_AND;
        case (w_op)
            OP_AND:  o_dec.alu_op = ALU_AND;
            OP_ADD:  o_dec.alu_op = ALU_ADD;
            OP_SUB:  o_dec.alu_op = ALU_SUB;
            OP_ADDI: begin
                o_dec.alu_op      = ALU_ADD;
                o_dec.alu_src_imm = 1'b1;
            end
            OP_LW: begin
                o_dec.alu_op      = ALU_ADD;
                o_dec.alu_src_imm = 1'b1;
                o_dec.wb_sel      = 1'b1;
                o_dec.is_mem      = 1'b1;
            end
            OP_SW: begin
                // Store data comes out on BusB, so port B reads rd.
                o_dec.alu_op      = ALU_ADD;
                o_dec.alu_src_imm = 1'b1;
                o_dec.is_mem      = 1'b1;
                o_dec.is_store    = 1'b1;
                o_dec.rf_rb       = w_rd;
            end
            OP_BEQ: begin
                o_dec.alu_op      = ALU_SUB;
                o_dec.is_branch   = 1'b1;
                o_dec.rf_rb       = w_rd;
            end
            OP_JMP:  o_dec.is_jump = 1'b1;
            OP_HALT: o_dec.is_halt = 1'b1;
            default: o_dec.is_illegal = op_is_reserved(w_op);
        endcase
    end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle control FSM: owns PC and IR, sequences FETCH/DECODE/EXEC/MEM/WB/HALT
// and drives the register file, ALU and memory handshakes with registered strobes.
module mc_control_unit
    import ctrl_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
)(
    input  logic              clk,
    input  logic              rst_n,
    mc_control_unit_if.master bus,
    output logic [PC_W-1:0]   pc,
    output logic              illegal_op,
    output logic              halted
);

    localparam logic [PC_W-1:0] JMP_MASK = PC_W'(16'h0FFF);

    state_t          r_state;
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_ir;
    logic            r_imem_req;
    logic            r_rf_rd_en;
    logic            r_rf_wr_en;
    logic            r_dmem_req;
    logic            r_dmem_we;
    logic            r_illegal_op;
    logic            r_halted;

    decode_t         w_dec;
    logic [PC_W-1:0] w_jump_target;
    logic [PC_W-1:0] w_branch_target;
    logic            w_fetch_done;

    instr_decode u_instr_decode (
        .i_ir  (r_ir),
        .o_dec (w_dec)
    );

    // Jump keeps the PC's upper bits and replaces the low 12.
    assign w_jump_target   = (r_pc & ~JMP_MASK) | (PC_W'(r_ir[11:0]) & JMP_MASK);
    assign w_branch_target = r_pc + PC_W'($signed(w_dec.imm_ext));
    assign w_fetch_done    = r_imem_req && bus.imem_valid;

    // Strobes are set on the transition into the state that owns them, so each
    // is high exactly while the FSM sits in that state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_FETCH;
            r_pc         <= RESET_PC;
            r_ir         <= '0;
            r_imem_req   <= 1'b0;
            r_rf_rd_en   <= 1'b0;
            r_rf_wr_en   <= 1'b0;
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_illegal_op <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_illegal_op <= 1'b0;
            case (r_state)
                ST_FETCH: begin
                    if (w_fetch_done) begin
                        r_ir         <= bus.imem_rdata;
                        r_pc         <= r_pc + PC_W'(1);
                        r_imem_req   <= 1'b0;
                        r_rf_rd_en   <= 1'b1;
                        r_illegal_op <= op_is_reserved(bus.imem_rdata[15:12]);
                        r_state      <= ST_DECODE;
                    end else begin
                        r_imem_req   <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    r_rf_rd_en <= 1'b0;
                    if (w_dec.is_jump) begin
                        r_pc       <= w_jump_target;
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end else if (w_dec.is_halt) begin
                        r_halted   <= 1'b1;
                        r_state    <= ST_HALT;
                    end else if (w_dec.is_illegal) begin
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end else begin
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (w_dec.is_branch) begin
                        if (bus.alu_zero) begin
                            r_pc <= w_branch_target;
                        end
                        r_imem_req <= 1'b1;
                        r_state    <= ST_FETCH;
                    end else if (w_dec.is_mem) begin
                        r_dmem_req <= 1'b1;
                        r_dmem_we  <= w_dec.is_store;
                        r_state    <= ST_MEM;
                    end else begin
                        r_rf_wr_en <= 1'b1;
                        r_state    <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (bus.dmem_ready) begin
                        r_dmem_req <= 1'b0;
                        r_dmem_we  <= 1'b0;
                        if (w_dec.is_store) begin
                            r_imem_req <= 1'b1;
                            r_state    <= ST_FETCH;
                        end else begin
                            r_rf_wr_en <= 1'b1;
                            r_state    <= ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    r_rf_wr_en <= 1'b0;
                    r_imem_req <= 1'b1;
                    r_state    <= ST_FETCH;
                end
                ST_HALT: begin
                    r_halted <= 1'b1;
                end
                default: begin
                    r_imem_req <= 1'b1;
                    r_state    <= ST_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_req    = r_imem_req;
    assign bus.imem_addr   = r_pc;
    assign bus.rf_ra       = w_dec.rf_ra;
    assign bus.rf_rb       = w_dec.rf_rb;
    assign bus.rf_rw       = w_dec.rf_rw;
    assign bus.rf_rd_en    = r_rf_rd_en;
    assign bus.rf_wr_en    = r_rf_wr_en;
    assign bus.alu_op      = w_dec.alu_op;
    assign bus.alu_src_imm = w_dec.alu_src_imm;
    assign bus.imm_ext     = w_dec.imm_ext;
    assign bus.wb_sel      = w_dec.wb_sel;
    assign bus.dmem_req    = r_dmem_req;
    assign bus.dmem_we     = r_dmem_we;

    assign pc         = r_pc;
    assign illegal_op = r_illegal_op;
    assign halted     = r_halted;

endmodule

// File: tb/tb_mc_control_unit.sv
// Directed bench for mc_control_unit: hand-computed expectations for each instruction class,
// wait-state handshakes, branch/jump targets, reserved opcodes, HALT and async reset.
module tb_mc_control_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        illegal_op;
    logic        halted;

    int checks;
    int errors;
    int cyc;
    int start_cyc;

    mc_control_unit_if #(.PC_W(16)) u_if ();

    mc_control_unit #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (u_if.master),
        .pc         (pc),
        .illegal_op (illegal_op),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end else begin
            $display("ok   %s = %0h (cycle %0d)", tag, got, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Entered on a FETCH cycle; returns in the DECODE cycle of the fetched word.
    task automatic do_fetch(input logic [15:0] instr, input int waits, input logic [15:0] exp_addr);
        start_cyc = cyc;
        chk("fetch_req", u_if.imem_req, 1);
        chk("fetch_addr", u_if.imem_addr, exp_addr);
        u_if.imem_valid = 1'b0;
        for (int i = 0; i < waits; i++) tick();
        if (waits > 0) chk("fetch_req_held", u_if.imem_req, 1);
        u_if.imem_valid = 1'b1;
        u_if.imem_rdata = instr;
        tick();
        u_if.imem_valid = 1'b0;
        chk("dec_rd_en", u_if.rf_rd_en, 1);
        chk("dec_req_low", u_if.imem_req, 0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        start_cyc = 0;
        rst_n  = 1'b0;
        u_if.imem_valid = 1'b1;
        u_if.imem_rdata = 16'h1312;
        u_if.alu_zero   = 1'b0;
        u_if.dmem_ready = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_pc", pc, 16'h0000);
        chk("rst_imem_req", u_if.imem_req, 0);
        chk("rst_wr_en", u_if.rf_wr_en, 0);
        chk("rst_halted", halted, 0);
        chk("rst_alu_op", u_if.alu_op, 0);
        chk("rst_dmem_req", u_if.dmem_req, 0);

        rst_n = 1'b1;
        u_if.imem_valid = 1'b0;
        tick();
        chk("post_rst_req", u_if.imem_req, 1);
        chk("post_rst_addr", u_if.imem_addr, 16'h0000);

        // Reset mid-FETCH with a word on the bus
        u_if.imem_valid = 1'b1;
        #2 rst_n = 1'b0;
        tick();
        chk("midrst_pc", pc, 16'h0000);
        chk("midrst_wr_en", u_if.rf_wr_en, 0);
        chk("midrst_rd_en", u_if.rf_rd_en, 0);
        chk("midrst_req", u_if.imem_req, 0);
        u_if.imem_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("rel_req", u_if.imem_req, 1);
        chk("rel_addr", u_if.imem_addr, 16'h0000);

        // ADD r3 = r1 + r2, two wait states
        do_fetch(16'h1312, 2, 16'h0000);
        chk("add_ra", u_if.rf_ra, 1);
        chk("add_rb", u_if.rf_rb, 2);
        chk("add_pc", pc, 16'h0001);
        tick();
        chk("add_alu_op", u_if.alu_op, 2'b01);
        chk("add_src_imm", u_if.alu_src_imm, 0);
        chk("add_exec_wr", u_if.rf_wr_en, 0);
        tick();
        chk("add_wb_wr", u_if.rf_wr_en, 1);
        chk("add_rw", u_if.rf_rw, 3);
        chk("add_wb_sel", u_if.wb_sel, 0);
        tick();
        chk("add_wr_pulse", u_if.rf_wr_en, 0);
        chk("add_cycles", cyc - start_cyc, 6);

        // LW r5 = M[r2 - 1], three memory wait states
        do_fetch(16'h452F, 0, 16'h0001);
        chk("lw_ra", u_if.rf_ra, 2);
        chk("lw_pc", pc, 16'h0002);
        tick();
        chk("lw_alu_op", u_if.alu_op, 2'b01);
        chk("lw_src_imm", u_if.alu_src_imm, 1);
        chk("lw_imm", u_if.imm_ext, 16'hFFFF);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("lw_dmem_req", u_if.dmem_req, 1);
            chk("lw_dmem_we", u_if.dmem_we, 0);
            u_if.dmem_ready = (i == 3);
            tick();
        end
        u_if.dmem_ready = 1'b0;
        chk("lw_req_drop", u_if.dmem_req, 0);
        chk("lw_wb_wr", u_if.rf_wr_en, 1);
        chk("lw_rw", u_if.rf_rw, 5);
        chk("lw_wb_sel", u_if.wb_sel, 1);
        tick();
        chk("lw_cycles", cyc - start_cyc, 8);

        // JMP to 10
        do_fetch(16'h700A, 0, 16'h0002);
        tick();
        chk("jmp_cycles", cyc - start_cyc, 2);

        // BEQ taken: 11 - 2 = 9
        do_fetch(16'h612E, 0, 16'h000A);
        chk("beq_ra", u_if.rf_ra, 2);
        chk("beq_rb", u_if.rf_rb, 1);
        chk("beq_pc", pc, 16'h000B);
        tick();
        chk("beq_alu_op", u_if.alu_op, 2'b10);
        chk("beq_src_imm", u_if.alu_src_imm, 0);
        chk("beq_exec_wr", u_if.rf_wr_en, 0);
        u_if.alu_zero = 1'b1;
        tick();
        u_if.alu_zero = 1'b0;
        chk("beq_cycles", cyc - start_cyc, 3);
        chk("beq_t_wr", u_if.rf_wr_en, 0);

        do_fetch(16'h700A, 0, 16'h0009);
        tick();

        // BEQ not taken: falls through to 11
        do_fetch(16'h612E, 0, 16'h000A);
        tick();
        chk("beqn_exec_wr", u_if.rf_wr_en, 0);
        tick();
        chk("beqn_wr", u_if.rf_wr_en, 0);

        // JMP keeps pc[15:12] = 0
        do_fetch(16'h7ABC, 0, 16'h000B);
        tick();

        // SW M[r2 + 1] = r3, ready immediately
        do_fetch(16'h5321, 0, 16'h0ABC);
        chk("sw_ra", u_if.rf_ra, 2);
        chk("sw_rb", u_if.rf_rb, 3);
        tick();
        chk("sw_src_imm", u_if.alu_src_imm, 1);
        chk("sw_imm", u_if.imm_ext, 16'h0001);
        tick();
        chk("sw_dmem_req", u_if.dmem_req, 1);
        chk("sw_dmem_we", u_if.dmem_we, 1);
        u_if.dmem_ready = 1'b1;
        tick();
        u_if.dmem_ready = 1'b0;
        chk("sw_req_drop", u_if.dmem_req, 0);
        chk("sw_wr", u_if.rf_wr_en, 0);
        chk("sw_cycles", cyc - start_cyc, 4);

        // ADDI r0 = r15 + 7
        do_fetch(16'h30F7, 0, 16'h0ABD);
        chk("addi_ra", u_if.rf_ra, 15);
        tick();
        chk("addi_src_imm", u_if.alu_src_imm, 1);
        chk("addi_imm", u_if.imm_ext, 16'h0007);
        tick();
        chk("addi_wr", u_if.rf_wr_en, 1);
        chk("addi_rw", u_if.rf_rw, 0);
        tick();

        // SUB r4 = r5 - r6
        do_fetch(16'h2456, 0, 16'h0ABE);
        chk("sub_rb", u_if.rf_rb, 6);
        tick();
        chk("sub_alu_op", u_if.alu_op, 2'b10);
        tick();
        chk("sub_rw", u_if.rf_rw, 4);
        tick();

        // Reserved opcode
        do_fetch(16'h9000, 0, 16'h0ABF);
        chk("ill_pulse", illegal_op, 1);
        tick();
        chk("ill_clear", illegal_op, 0);
        chk("ill_cycles", cyc - start_cyc, 2);

        // HALT
        do_fetch(16'hF000, 0, 16'h0AC0);
        chk("halt_dec", halted, 0);
        u_if.imem_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("halt_flag", halted, 1);
            chk("halt_req", u_if.imem_req, 0);
        end
        chk("halt_pc", pc, 16'h0AC1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
